// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: default widths, the
// static-input timeout and the measurement FSM state encoding.
package pwm_pkg;

  localparam int unsigned PWM_CW      = 32;
  localparam int unsigned PWM_TIMEOUT = 2**20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Three-flop synchronizer for the asynchronous PWM input, producing
// single-cycle rise/fall strobes and the synchronized level.
module sync_edge
  import pwm_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic pwm_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Next value of each synchronizer stage is simply the previous stage.
  always_comb begin
    s1_d = pwm_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer chain; s3 only serves as the delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;
  assign level = s2_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures a PWM waveform and reports it as the timer period/compare pair
// (top = period - 1, cmp = high time) that would regenerate it. A waveform
// without rising edges for TIMEOUT cycles is flagged as static.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CW      = PWM_CW,
  parameter int unsigned TIMEOUT = PWM_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          pwm_in,
  output logic [CW-1:0] top_out,
  output logic [CW-1:0] cmp_out,
  output logic          valid,
  output logic          static_det,
  output logic          level
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic rise;
  logic fall;
  logic at_limit;

  pwm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] high_lat_q, high_lat_d;
  logic [CW-1:0] top_q, top_d;
  logic [CW-1:0] cmp_q, cmp_d;
  logic          valid_q, valid_d;
  logic          static_q, static_d;

  sync_edge u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level)
  );

  assign at_limit = (cnt_q == CNT_MAX);

  // Cycle counter restarts at 1 on every rise so that on the next rise it
  // holds the full period; it saturates at the timeout to mark a static input.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (!at_limit) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Measurement FSM: latch the high time on fall, publish period and high
  // time on the following rise, and fall back to IDLE on timeout.
  always_comb begin
    state_d    = state_q;
    high_lat_d = high_lat_q;
    top_d      = top_q;
    cmp_d      = cmp_q;
    valid_d    = 1'b0;
    static_d   = static_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end else if (at_limit) begin
          static_d = 1'b1;
        end
      end
      HIGH: begin
        if (at_limit) begin
          static_d = 1'b1;
          state_d  = IDLE;
        end else if (fall) begin
          high_lat_d = cnt_q;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          top_d    = cnt_q - CNT_ONE;
          cmp_d    = high_lat_q;
          valid_d  = 1'b1;
          static_d = 1'b0;
          state_d  = HIGH;
        end else if (at_limit) begin
          static_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and result registers; reset discards any partial period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      top_q      <= '0;
      cmp_q      <= '0;
      valid_q    <= 1'b0;
      static_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      top_q      <= top_d;
      cmp_q      <= cmp_d;
      valid_q    <= valid_d;
      static_q   <= static_d;
    end
  end

  assign top_out    = top_q;
  assign cmp_out    = cmp_q;
  assign valid      = valid_q;
  assign static_det = static_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. dut_a uses a long timeout for the period
// measurements; dut_b shares its inputs but uses TIMEOUT=64 so the static
// detection can be exercised quickly.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          pwm_in;
  logic [CW-1:0] top_a, cmp_a, top_b, cmp_b;
  logic          valid_a, static_a, level_a;
  logic          valid_b, static_b, level_b;

  int checks = 0;
  int errors = 0;
  int gtick = 0;
  int seg_start = 0;
  int ph = 0;
  int off = 0;

  int          q_time[$];
  logic [31:0] q_top[$];
  logic [31:0] q_cmp[$];

  int exp_b_time[8] = '{12, 22, 32, 42, 52, 62, 162, 262};
  int exp_b_top[8]  = '{9, 9, 9, 9, 9, 9, 99, 99};
  int exp_b_cmp[8]  = '{3, 3, 3, 3, 3, 3, 50, 50};

  always #5 CLK = ~CLK;

  pwm_capture #(.CW(CW), .TIMEOUT(2048)) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .pwm_in     (pwm_in),
    .top_out    (top_a),
    .cmp_out    (cmp_a),
    .valid      (valid_a),
    .static_det (static_a),
    .level      (level_a)
  );

  pwm_capture #(.CW(CW), .TIMEOUT(64)) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .pwm_in     (pwm_in),
    .top_out    (top_b),
    .cmp_out    (cmp_b),
    .valid      (valid_b),
    .static_det (static_b),
    .level      (level_b)
  );

  // Compare a 32-bit observation against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare a single-bit observation against its expected value.
  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Log every dut_a result with its tick index relative to the segment start.
  task automatic recordValid();
    if (valid_a === 1'b1) begin
      q_time.push_back(gtick - seg_start);
      q_top.push_back(top_a);
      q_cmp.push_back(cmp_a);
    end
  endtask

  task automatic clearLog();
    q_time.delete();
    q_top.delete();
    q_cmp.delete();
  endtask

  // Emulate the timer: output high while phase < cmp, phase wraps after top.
  // One call step is one clock cycle; outputs are sampled at the negedge.
  task automatic applyStimulus(input int top, input int cmp, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = (ph < cmp);
      @(negedge CLK);
      recordValid();
      gtick++;
      ph = (ph >= top) ? 0 : ph + 1;
    end
  endtask

  initial begin
    // Reset state of both instances.
    RST    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_top_a", top_a, 32'd0);
    checkOutput("rst_cmp_a", cmp_a, 32'd0);
    checkFlag("rst_valid_a", valid_a, 1'b0);
    checkFlag("rst_static_a", static_a, 1'b0);
    checkFlag("rst_level_a", level_a, 1'b0);
    checkOutput("rst_top_b", top_b, 32'd0);
    checkFlag("rst_static_b", static_b, 1'b0);
    RST = 1'b0;

    // top=9/cmp=3 for six periods, then switch to top=99/cmp=50 at a boundary.
    gtick = 0; seg_start = 0; ph = 0;
    clearLog();
    applyStimulus(9, 3, 60);
    ph = 0;
    applyStimulus(99, 50, 300);
    checkOutput("sw_count", q_time.size(), 32'd8);
    for (int i = 0; i < q_time.size() && i < 8; i++) begin
      checkOutput($sformatf("sw_time%0d", i), q_time[i], exp_b_time[i]);
      checkOutput($sformatf("sw_top%0d", i), q_top[i], exp_b_top[i]);
      checkOutput($sformatf("sw_cmp%0d", i), q_cmp[i], exp_b_cmp[i]);
    end

    // Minimum waveform: alternating 1/0, one result every 2 cycles.
    ph = 0; seg_start = gtick;
    clearLog();
    applyStimulus(1, 1, 40);
    checkOutput("min_count", q_time.size(), 32'd19);
    if (q_time.size() > 0) begin
      checkOutput("min_first_time", q_time[0], 32'd2);
      checkOutput("min_first_top", q_top[0], 32'd99);
      checkOutput("min_first_cmp", q_cmp[0], 32'd50);
    end
    for (int i = 1; i < q_time.size(); i++) begin
      checkOutput($sformatf("min_time%0d", i), q_time[i], 2 + 2 * i);
      checkOutput($sformatf("min_top%0d", i), q_top[i], 32'd1);
      checkOutput($sformatf("min_cmp%0d", i), q_cmp[i], 32'd1);
    end

    // Static low on dut_b: last rise input at local tick 20, flag after tick 86.
    ph = 0; seg_start = gtick;
    applyStimulus(9, 3, 30);
    applyStimulus(9, 0, 56);
    checkFlag("low_static_early", static_b, 1'b0);
    applyStimulus(9, 0, 1);
    checkFlag("low_static_set", static_b, 1'b1);
    checkFlag("low_level", level_b, 1'b0);
    checkFlag("low_valid", valid_b, 1'b0);
    checkOutput("low_top_hold", top_b, 32'd9);
    checkOutput("low_cmp_hold", cmp_b, 32'd3);

    // Restart: first rise only re-arms, second one reports and clears static.
    ph = 0; seg_start = gtick;
    applyStimulus(9, 3, 12);
    checkFlag("restart_valid_early", valid_b, 1'b0);
    checkFlag("restart_static_held", static_b, 1'b1);
    applyStimulus(9, 3, 1);
    checkFlag("restart_valid", valid_b, 1'b1);
    checkFlag("restart_static_clr", static_b, 1'b0);
    checkOutput("restart_top", top_b, 32'd9);
    checkOutput("restart_cmp", cmp_b, 32'd3);

    // Static high: input stays high from local tick 10, flag after tick 76.
    applyStimulus(9, 10, 63);
    checkFlag("high_static_early", static_b, 1'b0);
    applyStimulus(9, 10, 1);
    checkFlag("high_static_set", static_b, 1'b1);
    checkFlag("high_level", level_b, 1'b1);
    checkOutput("high_top_hold", top_b, 32'd9);
    checkOutput("high_cmp_hold", cmp_b, 32'd3);

    // One-cycle reset during the HIGH phase of top=19/cmp=5.
    ph = 0; seg_start = gtick;
    applyStimulus(19, 5, 24);
    RST = 1'b1;
    applyStimulus(19, 5, 1);
    RST = 1'b0;
    checkOutput("mid_rst_top", top_a, 32'd0);
    checkOutput("mid_rst_cmp", cmp_a, 32'd0);
    checkFlag("mid_rst_valid", valid_a, 1'b0);
    checkFlag("mid_rst_static", static_a, 1'b0);
    checkFlag("mid_rst_level", level_a, 1'b0);
    clearLog();
    applyStimulus(19, 5, 38);
    checkOutput("post_rst_count", q_time.size(), 32'd1);
    if (q_time.size() > 0) begin
      checkOutput("post_rst_time", q_time[0], 32'd62);
      checkOutput("post_rst_top", q_top[0], 32'd19);
      checkOutput("post_rst_cmp", q_cmp[0], 32'd5);
    end

    // Let dut_a time out so the asynchronous run starts from IDLE.
    applyStimulus(9, 0, 2100);
    checkFlag("a_static_set", static_a, 1'b1);
    checkOutput("a_top_hold", top_a, 32'd19);
    checkOutput("a_cmp_hold", cmp_a, 32'd5);

    // Asynchronous input, top=999/cmp=333, edges placed off the clock grid.
    seg_start = gtick;
    clearLog();
    off = $urandom_range(1, 8);
    if (off >= 5) off++;
    fork
      begin
        #(off);
        repeat (6) begin
          pwm_in = 1'b1;
          #3330;
          pwm_in = 1'b0;
          #6670;
        end
      end
      begin
        repeat (6000) begin
          @(negedge CLK);
          recordValid();
          gtick++;
        end
      end
    join
    checkOutput("async_count", q_time.size(), 32'd5);
    for (int i = 0; i < q_time.size(); i++) begin
      checkFlag($sformatf("async_top%0d_range", i), (q_top[i] >= 998 && q_top[i] <= 1000), 1'b1);
      checkFlag($sformatf("async_cmp%0d_range", i), (q_cmp[i] >= 332 && q_cmp[i] <= 334), 1'b1);
    end
    checkFlag("async_static_clr", static_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
